// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder: vector input, index output, status.
// The out_remain member exists only when PRIO_SCAN_COUNT_EN is defined.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
`ifdef PRIO_SCAN_COUNT_EN
  logic [IDX_W:0]   out_remain;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy
`ifdef PRIO_SCAN_COUNT_EN
    , input out_remain
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy
`ifdef PRIO_SCAN_COUNT_EN
    , output out_remain
`endif
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: accepts a request vector, then emits every set index in
// priority order, one per output handshake. Optional macro PRIO_SCAN_COUNT_EN adds out_remain.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a vector; zero vectors are accepted and dropped
// ST_SCAN | presenting the highest-priority pending index
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  priority_scan_encoder_if.slave io_bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic [WIDTH-1:0] w_clear_mask;

  function automatic logic [IDX_W-1:0] f_prio(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // later hits overwrite earlier ones, so scan toward the priority end
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  assign w_idx        = f_prio(r_pending);
  assign w_clear_mask = WIDTH'(1) << w_idx;

`ifdef PRIO_SCAN_COUNT_EN
  function automatic logic [IDX_W:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + (IDX_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  logic [IDX_W:0] w_remain;

  assign w_remain          = f_popcount(r_pending);
  assign w_last            = (w_remain == (IDX_W+1)'(1));
  assign io_bus.out_remain = w_remain;
`else
  assign w_last = (r_pending != '0) && ((r_pending & (r_pending - WIDTH'(1))) == '0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_in_ready    = 1'b0;
    w_out_valid   = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid && (io_bus.in_data != '0)) begin
          w_pending_nxt = io_bus.in_data;
          w_state_nxt   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        if (io_bus.out_ready) begin
          if (w_last) begin
            w_pending_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_pending_nxt = r_pending & ~w_clear_mask;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.busy      = w_busy;
  assign io_bus.out_idx   = w_idx;
  assign io_bus.out_last  = w_last;
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Self-checking bench: three encoders (8/MSB, 8/LSB, 16/MSB) share one stimulus stream and
// are compared every cycle against queue-based reference models of the served index order.
module tb_priority_scan_encoder;
  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic        tb_in_valid = 1'b0;
  logic [7:0]  tb_in_data = '0;
  logic [15:0] tbc_data = '0;
  logic        tb_out_ready = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          qa[$];
  int          qb[$];
  int          qc[$];

  always #5 clk = ~clk;

  priority_scan_encoder_if #(.WIDTH(8))  ifa ();
  priority_scan_encoder_if #(.WIDTH(8))  ifb ();
  priority_scan_encoder_if #(.WIDTH(16)) ifc ();

  assign ifa.in_valid  = tb_in_valid;
  assign ifa.in_data   = tb_in_data;
  assign ifa.out_ready = tb_out_ready;
  assign ifb.in_valid  = tb_in_valid;
  assign ifb.in_data   = tb_in_data;
  assign ifb.out_ready = tb_out_ready;
  assign ifc.in_valid  = tb_in_valid;
  assign ifc.in_data   = tbc_data;
  assign ifc.out_ready = tb_out_ready;

  priority_scan_encoder #(.WIDTH(8),  .MSB_FIRST(1'b1)) dut_a (.i_clk(clk), .i_rst(tb_rst), .io_bus(ifa));
  priority_scan_encoder #(.WIDTH(8),  .MSB_FIRST(1'b0)) dut_b (.i_clk(clk), .i_rst(tb_rst), .io_bus(ifb));
  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_c (.i_clk(clk), .i_rst(tb_rst), .io_bus(ifc));

  function automatic logic [15:0] pk(logic v, logic r, logic b, logic l, logic [4:0] idx, logic [5:0] rem);
    return {1'b0, v, r, b, l, idx, rem};
  endfunction

  function automatic logic [15:0] obs(int k);
    logic [5:0] rem;
    rem = '0;
    if (k == 0) begin
`ifdef PRIO_SCAN_COUNT_EN
      rem = 6'(ifa.out_remain);
`endif
      return pk(ifa.out_valid, ifa.in_ready, ifa.busy, ifa.out_last, 5'(ifa.out_idx), rem);
    end else if (k == 1) begin
`ifdef PRIO_SCAN_COUNT_EN
      rem = 6'(ifb.out_remain);
`endif
      return pk(ifb.out_valid, ifb.in_ready, ifb.busy, ifb.out_last, 5'(ifb.out_idx), rem);
    end
`ifdef PRIO_SCAN_COUNT_EN
    rem = 6'(ifc.out_remain);
`endif
    return pk(ifc.out_valid, ifc.in_ready, ifc.busy, ifc.out_last, 5'(ifc.out_idx), rem);
  endfunction

  // expected outputs follow directly from the list of not-yet-served indices
  function automatic logic [15:0] expv(int k);
    int sz;
    int head;
    logic [5:0] rem;
    sz   = (k == 0) ? qa.size() : (k == 1) ? qb.size() : qc.size();
    head = 0;
    if (sz > 0) head = (k == 0) ? qa[0] : (k == 1) ? qb[0] : qc[0];
    rem = '0;
`ifdef PRIO_SCAN_COUNT_EN
    rem = 6'(sz);
`endif
    return pk(sz > 0, sz == 0, sz > 0, sz == 1, 5'(head), rem);
  endfunction

  task automatic model_edge();
    if (tb_rst) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (qa.size() > 0) begin
        if (tb_out_ready) qa.delete(0);
      end else if (tb_in_valid) begin
        for (int i = 7; i >= 0; i--) if (tb_in_data[i]) qa.push_back(i);
      end
      if (qb.size() > 0) begin
        if (tb_out_ready) qb.delete(0);
      end else if (tb_in_valid) begin
        for (int i = 0; i < 8; i++) if (tb_in_data[i]) qb.push_back(i);
      end
      if (qc.size() > 0) begin
        if (tb_out_ready) qc.delete(0);
      end else if (tb_in_valid) begin
        for (int i = 15; i >= 0; i--) if (tbc_data[i]) qc.push_back(i);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tb_rst = 1'b1; tb_in_valid = 1'b1; tb_in_data = 8'hFF; tbc_data = 16'hFFFF; tb_out_ready = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), expv(k));
      end
    end
    tb_rst = 1'b0; tb_in_valid = 1'b0; tb_in_data = '0; tbc_data = '0; tb_out_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d got=%h exp=%h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_pattern();
    int seen_a[$];
    int seen_b[$];
    int seen_c[$];
    int lasts_a;
    int exp_a[4];
    int exp_b[4];
    exp_a = '{7, 5, 2, 0};
    exp_b = '{0, 2, 5, 7};
    lasts_a = 0;
    tb_in_valid = 1'b1; tb_in_data = 8'hA5; tbc_data = 16'h8000; tb_out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL pattern c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      if (ifa.out_valid) seen_a.push_back(int'(ifa.out_idx));
      if (ifa.out_valid && ifa.out_last) lasts_a++;
      if (ifb.out_valid) seen_b.push_back(int'(ifb.out_idx));
      if (ifc.out_valid) seen_c.push_back(int'(ifc.out_idx));
      tick();
      tb_in_valid = 1'b0;
    end
    n_checks++;
    if (seen_a.size() != 4 || seen_b.size() != 4) begin
      n_fail++;
      $display("FAIL pattern_len got=%0d/%0d exp=4/4", seen_a.size(), seen_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen_a[i] != exp_a[i] || seen_b[i] != exp_b[i]) begin
          n_fail++;
          $display("FAIL pattern_seq i%0d got=%0d/%0d exp=%0d/%0d", i, seen_a[i], seen_b[i], exp_a[i], exp_b[i]);
        end
      end
    end
    n_checks++;
    if (lasts_a != 1) begin
      n_fail++;
      $display("FAIL pattern_last got=%0d exp=1", lasts_a);
    end
    n_checks++;
    if (seen_c.size() != 1 || (seen_c.size() == 1 && seen_c[0] != 15)) begin
      n_fail++;
      $display("FAIL wide_single got_count=%0d exp=1 (index 15)", seen_c.size());
    end
  endtask

  task automatic test_backpressure();
    tb_in_valid = 1'b1; tb_in_data = 8'h12; tbc_data = 16'h0101; tb_out_ready = 1'b0;
    tick();
    tb_in_data = 8'hFF; tbc_data = 16'hFFFF;
    for (int c = 0; c < 7; c++) begin
      tb_out_ready = (c >= 3);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL backpressure c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      if (c < 3) begin
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_idx !== 3'd4) begin
          n_fail++;
          $display("FAIL backpressure_hold c%0d got=%b/%0d exp=1/4", c, ifa.out_valid, ifa.out_idx);
        end
      end
      if (c == 4) tb_in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_zero();
    tb_in_valid = 1'b1; tb_in_data = 8'h00; tbc_data = 16'h0000; tb_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL zero c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
    end
    tb_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    tb_in_valid = 1'b1; tb_in_data = 8'hFF; tbc_data = 16'hFFFF; tb_out_ready = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL midreset_scan c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      tick();
    end
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle got v/r/b=%b%b%b exp=010", ifa.out_valid, ifa.in_ready, ifa.busy);
    end
    tb_in_valid = 1'b1; tb_in_data = 8'h01; tbc_data = 16'h0001;
    tick();
    tb_in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL midreset_after c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      if (c == 0) begin
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_idx !== 3'd0 || ifa.out_last !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_single got v/idx/last=%b/%0d/%b exp=1/0/1", ifa.out_valid, ifa.out_idx, ifa.out_last);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tb_in_data = 8'($urandom);
      tbc_data   = 16'($urandom);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL back_to_back c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      tick();
    end
    tb_in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tb_rst       = ($urandom_range(0, 59) == 0);
      tb_in_valid  = $urandom_range(0, 1) == 1;
      tb_in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tbc_data     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      tb_out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
        end
      end
      tick();
    end
    tb_rst = 1'b0; tb_in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pattern();
    test_backpressure();
    test_zero();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
